// File: rtl/retire_pkg.sv
// Shared types and default sizes for the dual-lane retire unit.
package retire_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } lane_state_t;

  // Write-port record is sized to the package defaults.
  typedef struct packed {
    logic                  we;
    logic [REG_AW_DEF-1:0] regd;
    logic [XLEN_DEF-1:0]   data;
  } wb_port_t;

endpackage

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier producing the low XLEN bits of a*b in XLEN steps.
module seq_multiplier
  import retire_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic            last,
  output logic [XLEN-1:0] product_lo
);

  localparam int CW = $clog2(XLEN);

  logic [CW-1:0]   count;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;

  // last is high during the cycle whose edge performs the final step
  assign last       = busy && (count == CW'(XLEN - 1));
  assign product_lo = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy   <= 1'b1;
        count  <= '0;
        mcand  <= a;
        mplier <= b;
        acc    <= '0;
      end else if (busy) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + 1'b1;
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dual_lane_retire_unit.sv
// Two-lane responder: retires ALU results next cycle, runs multiplies iteratively,
// drives the dual-write register file and exports a busy-register scoreboard.
module dual_lane_retire_unit
  import retire_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_en1,
  input  logic                   issue_mul1,
  input  logic [REG_AW-1:0]      issue_regd1,
  input  logic [XLEN-1:0]        issue_a1,
  input  logic [XLEN-1:0]        issue_b1,
  input  logic [XLEN-1:0]        issue_res1,
  output logic                   ack1,
  input  logic                   issue_en2,
  input  logic                   issue_mul2,
  input  logic [REG_AW-1:0]      issue_regd2,
  input  logic [XLEN-1:0]        issue_a2,
  input  logic [XLEN-1:0]        issue_b2,
  input  logic [XLEN-1:0]        issue_res2,
  output logic                   ack2,
  output logic                   wb_we1,
  output logic [REG_AW-1:0]      wb_regd1,
  output logic [XLEN-1:0]        wb_data1,
  output logic                   wb_we2,
  output logic [REG_AW-1:0]      wb_regd2,
  output logic [XLEN-1:0]        wb_data2,
  output logic [2**REG_AW-1:0]   busy_regs
);

  localparam int NREG = 2**REG_AW;

  lane_state_t       state [2];
  logic [1:0]        lane_en;
  logic [1:0]        lane_mul;
  logic [1:0]        fire;
  logic [1:0]        mul_last;
  logic [1:0]        mul_busy;
  logic [1:0]        mul_done;
  logic [REG_AW-1:0] lane_regd [2];
  logic [XLEN-1:0]   lane_res [2];
  logic [XLEN-1:0]   product [2];
  logic [REG_AW-1:0] mul_regd [2];
  logic [1:0]        pend_valid;
  logic [REG_AW-1:0] pend_regd [2];
  logic [XLEN-1:0]   pend_data [2];
  wb_port_t          cand [2];
  logic [1:0]        we_final;
  logic [NREG-1:0]   set_bits;
  logic [NREG-1:0]   clr_bits;
  logic              unused_mul_status;

  assign lane_en      = {issue_en2, issue_en1};
  assign lane_mul     = {issue_mul2, issue_mul1};
  assign lane_regd[0] = issue_regd1;
  assign lane_regd[1] = issue_regd2;
  assign lane_res[0]  = issue_res1;
  assign lane_res[1]  = issue_res2;

  assign ack1 = (state[0] != MUL);
  assign ack2 = (state[1] != MUL);
  assign fire = lane_en & {ack2, ack1};

  assign unused_mul_status = ^{mul_busy, mul_done};

  seq_multiplier #(.XLEN(XLEN)) u_mul1 (
    .clk        (clk),
    .rst        (rst),
    .start      (fire[0] && lane_mul[0]),
    .a          (issue_a1),
    .b          (issue_b1),
    .busy       (mul_busy[0]),
    .done       (mul_done[0]),
    .last       (mul_last[0]),
    .product_lo (product[0])
  );

  seq_multiplier #(.XLEN(XLEN)) u_mul2 (
    .clk        (clk),
    .rst        (rst),
    .start      (fire[1] && lane_mul[1]),
    .a          (issue_a2),
    .b          (issue_b2),
    .busy       (mul_busy[1]),
    .done       (mul_done[1]),
    .last       (mul_last[1]),
    .product_lo (product[1])
  );

  // Lane FSMs plus a one-deep hold slot for ALU results displaced by a DONE writeback.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        state[i]      <= IDLE;
        pend_valid[i] <= 1'b0;
        pend_regd[i]  <= '0;
        pend_data[i]  <= '0;
        mul_regd[i]   <= '0;
      end else begin
        unique case (state[i])
          IDLE: begin
            if (fire[i] && lane_mul[i]) begin
              state[i]    <= MUL;
              mul_regd[i] <= lane_regd[i];
            end
          end
          MUL: begin
            if (mul_last[i]) state[i] <= DONE;
          end
          DONE: begin
            if (fire[i] && lane_mul[i]) begin
              state[i]    <= MUL;
              mul_regd[i] <= lane_regd[i];
            end else begin
              state[i] <= IDLE;
            end
          end
          default: state[i] <= IDLE;
        endcase

        if (fire[i] && !lane_mul[i] && (state[i] == DONE || pend_valid[i])) begin
          pend_valid[i] <= 1'b1;
          pend_regd[i]  <= lane_regd[i];
          pend_data[i]  <= lane_res[i];
        end else if (state[i] != DONE) begin
          pend_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Per-lane retirement candidate: DONE product, then held result, then fresh ALU issue.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cand[i] = '0;
      if (state[i] == DONE) begin
        cand[i].we   = 1'b1;
        cand[i].regd = mul_regd[i];
        cand[i].data = product[i];
      end else if (pend_valid[i]) begin
        cand[i].we   = 1'b1;
        cand[i].regd = pend_regd[i];
        cand[i].data = pend_data[i];
      end else if (fire[i] && !lane_mul[i]) begin
        cand[i].we   = 1'b1;
        cand[i].regd = lane_regd[i];
        cand[i].data = lane_res[i];
      end
    end
  end

  // x0 writes are dropped; on a same-register collision lane 2 (younger) wins.
  always_comb begin
    we_final[1] = cand[1].we && (cand[1].regd != '0);
    we_final[0] = cand[0].we && (cand[0].regd != '0) &&
                  !(we_final[1] && (cand[1].regd == cand[0].regd));
  end

  // A completing lane keeps the bit if the other lane still has a multiply in flight to it.
  always_comb begin
    set_bits = '0;
    clr_bits = '0;
    for (int i = 0; i < 2; i++) begin
      if (fire[i] && lane_mul[i] && (lane_regd[i] != '0)) set_bits[lane_regd[i]] = 1'b1;
      if (state[i] == DONE &&
          !(state[1-i] == MUL && mul_regd[1-i] == mul_regd[i]))
        clr_bits[mul_regd[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we1    <= 1'b0;
      wb_regd1  <= '0;
      wb_data1  <= '0;
      wb_we2    <= 1'b0;
      wb_regd2  <= '0;
      wb_data2  <= '0;
      busy_regs <= '0;
    end else begin
      wb_we1 <= we_final[0];
      wb_we2 <= we_final[1];
      if (cand[0].we) begin
        wb_regd1 <= cand[0].regd;
        wb_data1 <= cand[0].data;
      end
      if (cand[1].we) begin
        wb_regd2 <= cand[1].regd;
        wb_data2 <= cand[1].data;
      end
      busy_regs <= (busy_regs & ~clr_bits) | set_bits;
    end
  end

endmodule

// File: tb/tb_dual_lane_retire_unit.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_dual_lane_retire_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_en1, issue_mul1, issue_en2, issue_mul2;
  logic [4:0]  issue_regd1, issue_regd2;
  logic [31:0] issue_a1, issue_b1, issue_res1, issue_a2, issue_b2, issue_res2;
  logic        ack1, ack2;
  logic        wb_we1, wb_we2;
  logic [4:0]  wb_regd1, wb_regd2;
  logic [31:0] wb_data1, wb_data2;
  logic [31:0] busy_regs;

  dual_lane_retire_unit dut (
    .clk(clk), .rst(rst),
    .issue_en1(issue_en1), .issue_mul1(issue_mul1), .issue_regd1(issue_regd1),
    .issue_a1(issue_a1), .issue_b1(issue_b1), .issue_res1(issue_res1), .ack1(ack1),
    .issue_en2(issue_en2), .issue_mul2(issue_mul2), .issue_regd2(issue_regd2),
    .issue_a2(issue_a2), .issue_b2(issue_b2), .issue_res2(issue_res2), .ack2(ack2),
    .wb_we1(wb_we1), .wb_regd1(wb_regd1), .wb_data1(wb_data1),
    .wb_we2(wb_we2), .wb_regd2(wb_regd2), .wb_data2(wb_data2),
    .busy_regs(busy_regs)
  );

  always #5 clk = ~clk;

  // Reference model: per-lane queue of pending ALU results, one in-flight multiply per lane.
  typedef struct {
    logic [4:0]  regd;
    logic [31:0] data;
  } ret_t;

  ret_t        ret_q [2][$];
  int unsigned edge_n = 0;
  bit          mul_active [2];
  int unsigned mul_edge [2];
  logic [4:0]  mul_regd [2];
  logic [31:0] mul_prod [2];
  bit          exp_ack [2];
  bit          exp_we [2];
  logic [4:0]  exp_regd [2];
  logic [31:0] exp_data [2];
  logic [31:0] exp_busy;
  bit          last_rst;
  int          checks = 0;
  int          fails  = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: observed %0h required %0h (edge %0d)", tag, got, want, edge_n);
    end
  endtask

  task automatic modelEdge();
    bit          en [2], mul [2], c_we [2];
    logic [4:0]  rd [2], c_rd [2];
    logic [31:0] a [2], b [2], res [2], c_dt [2];
    ret_t        e;
    en[0] = issue_en1;  mul[0] = issue_mul1; rd[0] = issue_regd1;
    a[0]  = issue_a1;   b[0]   = issue_b1;   res[0] = issue_res1;
    en[1] = issue_en2;  mul[1] = issue_mul2; rd[1] = issue_regd2;
    a[1]  = issue_a2;   b[1]   = issue_b2;   res[1] = issue_res2;
    last_rst = rst;
    if (rst) begin
      for (int l = 0; l < 2; l++) begin
        ret_q[l].delete();
        mul_active[l] = 0;
        exp_ack[l]    = 1;
        exp_we[l]     = 0;
        exp_regd[l]   = '0;
        exp_data[l]   = '0;
      end
      exp_busy = '0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        c_we[l] = 0; c_rd[l] = '0; c_dt[l] = '0;
        if (mul_active[l] && edge_n == mul_edge[l] + 33) begin
          c_we[l] = 1; c_rd[l] = mul_regd[l]; c_dt[l] = mul_prod[l];
          mul_active[l] = 0;
        end
        if (en[l] && exp_ack[l]) begin
          if (mul[l]) begin
            mul_active[l] = 1;
            mul_edge[l]   = edge_n;
            mul_regd[l]   = rd[l];
            mul_prod[l]   = a[l] * b[l];
          end else begin
            ret_q[l].push_back('{rd[l], res[l]});
          end
        end
        if (!c_we[l] && ret_q[l].size() > 0) begin
          e = ret_q[l].pop_front();
          c_we[l] = 1; c_rd[l] = e.regd; c_dt[l] = e.data;
        end
        exp_ack[l] = !(mul_active[l] && edge_n < mul_edge[l] + 32);
        if (c_we[l]) begin
          exp_regd[l] = c_rd[l];
          exp_data[l] = c_dt[l];
        end
      end
      exp_we[0] = c_we[0] && (c_rd[0] != 0);
      exp_we[1] = c_we[1] && (c_rd[1] != 0);
      if (exp_we[0] && exp_we[1] && c_rd[0] == c_rd[1]) exp_we[0] = 0;
      exp_busy = '0;
      for (int l = 0; l < 2; l++)
        if (mul_active[l] && mul_regd[l] != 0) exp_busy[mul_regd[l]] = 1'b1;
    end
    edge_n++;
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("ack1", ack1, exp_ack[0]);
    checkOutput("ack2", ack2, exp_ack[1]);
    checkOutput("wb_we1", wb_we1, exp_we[0]);
    checkOutput("wb_we2", wb_we2, exp_we[1]);
    checkOutput("busy_regs", busy_regs, exp_busy);
    if (exp_we[0] || last_rst) begin
      checkOutput("wb_regd1", wb_regd1, exp_regd[0]);
      checkOutput("wb_data1", wb_data1, exp_data[0]);
    end
    if (exp_we[1] || last_rst) begin
      checkOutput("wb_regd2", wb_regd2, exp_regd[1]);
      checkOutput("wb_data2", wb_data2, exp_data[1]);
    end
  endtask

  task automatic applyStimulus(input int lane, input bit en, input bit mul, input logic [4:0] rd,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] res);
    if (lane == 1) begin
      issue_en1 = en; issue_mul1 = mul; issue_regd1 = rd;
      issue_a1 = a; issue_b1 = b; issue_res1 = res;
    end else begin
      issue_en2 = en; issue_mul2 = mul; issue_regd2 = rd;
      issue_a2 = a; issue_b2 = b; issue_res2 = res;
    end
  endtask

  task automatic idleLanes();
    applyStimulus(1, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
    applyStimulus(2, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    idleLanes();
    step();
    step();
    rst = 1'b0;

    // Back-to-back ALU issues on both lanes
    applyStimulus(1, 1, 0, 5'd3, 32'd0, 32'd0, 32'h11);
    applyStimulus(2, 1, 0, 5'd4, 32'd0, 32'd0, 32'h22);
    repeat (4) step();
    checkOutput("alu_data1", wb_data1, 32'h11);
    checkOutput("alu_data2", wb_data2, 32'h22);
    idleLanes();
    step();

    // Lane 1 multiply 7*6 -> r5
    applyStimulus(1, 1, 1, 5'd5, 32'd7, 32'd6, 32'd0);
    step();
    idleLanes();
    checkOutput("mul_ack1_low", ack1, 1'b0);
    checkOutput("mul_busy5_set", busy_regs[5], 1'b1);
    repeat (32) step();
    checkOutput("mul_we1_early", wb_we1, 1'b0);
    step();
    checkOutput("mul_we1", wb_we1, 1'b1);
    checkOutput("mul_data1", wb_data1, 32'd42);
    checkOutput("mul_busy5_clr", busy_regs[5], 1'b0);

    // Lane 2 multiply while lane 1 streams ALU results
    applyStimulus(2, 1, 1, 5'd6, 32'hFFFF_FFFF, 32'd2, 32'd0);
    applyStimulus(1, 1, 0, 5'd10, 32'd0, 32'd0, $urandom);
    step();
    applyStimulus(2, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
    for (int k = 0; k < 33; k++) begin
      applyStimulus(1, 1, 0, 5'd10, 32'd0, 32'd0, $urandom);
      step();
    end
    checkOutput("mul2_we2", wb_we2, 1'b1);
    checkOutput("mul2_data2", wb_data2, 32'hFFFF_FFFE);
    idleLanes();
    step();

    // Same-register collision and x0 destination
    applyStimulus(1, 1, 0, 5'd9, 32'd0, 32'd0, 32'd1);
    applyStimulus(2, 1, 0, 5'd9, 32'd0, 32'd0, 32'd2);
    step();
    checkOutput("waw_we1", wb_we1, 1'b0);
    checkOutput("waw_we2", wb_we2, 1'b1);
    checkOutput("waw_data2", wb_data2, 32'd2);
    applyStimulus(1, 1, 0, 5'd0, 32'd0, 32'd0, 32'h33);
    applyStimulus(2, 1, 0, 5'd0, 32'd0, 32'd0, 32'h44);
    step();
    checkOutput("x0_we1", wb_we1, 1'b0);
    checkOutput("x0_we2", wb_we2, 1'b0);
    idleLanes();
    step();

    // Reset part-way through a multiply to r7
    applyStimulus(1, 1, 1, 5'd7, 32'd5, 32'd5, 32'd0);
    step();
    idleLanes();
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("abort_ack1", ack1, 1'b1);
    checkOutput("abort_busy", busy_regs, 32'd0);
    repeat (40) step();

    // ALU issue accepted in the DONE cycle of a 3*3 -> r8 multiply
    applyStimulus(1, 1, 1, 5'd8, 32'd3, 32'd3, 32'd0);
    step();
    idleLanes();
    repeat (32) step();
    checkOutput("done_ack1", ack1, 1'b1);
    applyStimulus(1, 1, 0, 5'd2, 32'd0, 32'd0, 32'h55);
    step();
    idleLanes();
    checkOutput("done_wb_regd", wb_regd1, 5'd8);
    checkOutput("done_wb_data", wb_data1, 32'd9);
    step();
    checkOutput("held_wb_we", wb_we1, 1'b1);
    checkOutput("held_wb_regd", wb_regd1, 5'd2);
    checkOutput("held_wb_data", wb_data1, 32'h55);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int l = 1; l <= 2; l++)
        applyStimulus(l, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                      5'($urandom_range(0, 15)), $urandom, $urandom, $urandom);
      step();
    end
    rst = 1'b0;
    idleLanes();
    repeat (40) step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
